// File: rtl/demux_rr_dispatcher_pkg.sv
// Shared constants for the round-robin demux dispatcher: channel count, counter width, FSM encoding.
package demux_rr_dispatcher_pkg;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

endpackage

// File: rtl/demux_rr_dispatcher_rr_pick.sv
// Combinational round-robin search: first set mask bit strictly after ptr, wrapping back to ptr itself.
module rr_pick
    import demux_rr_dispatcher_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [1:0]        ptr,
    output logic [1:0]        idx,
    output logic              found
);

    logic [1:0] cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        // k = 4 wraps to ptr itself, so the last granted channel is tried last
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = ptr + 2'(k);
            if (!found && mask[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// 1-to-4 round-robin dispatcher with a single holding register; item accepted in cycle N is presented in N+1.
// Backpressure: in_ready drops while the held item's channel is not ready or no channel is enabled.
module demux_rr_dispatcher
    import demux_rr_dispatcher_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en_mask,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    output logic [NUM_CH-1:0] out_valid,
    output logic [WIDTH-1:0]  out_data,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [1:0]        sel,
    output logic [CNT_W-1:0]  xfer_cnt
);

    logic [0:0] state;
    logic [1:0] lp;
    logic [1:0] lp_eff;
    logic [1:0] pick_idx;
    logic       pick_found;
    logic       xfer;
    logic       accept;

    assign xfer = out_valid[sel] && out_ready[sel];

    // Search from the pointer as it will be after this cycle's transfer, for back-to-back throughput
    assign lp_eff = xfer ? sel : lp;

    rr_pick u_rr_pick (
        .mask  (en_mask),
        .ptr   (lp_eff),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // pick_found is set exactly when en_mask is nonzero
    assign in_ready = rst_n && pick_found && ((state == ST_IDLE) || out_ready[sel]);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out_valid <= '0;
            out_data  <= '0;
            sel       <= 2'd0;
            lp        <= 2'd3;
            xfer_cnt  <= '0;
        end else begin
            if (xfer) begin
                lp       <= sel;
                xfer_cnt <= xfer_cnt + 1'b1;
            end
            if (accept) begin
                state     <= ST_HOLD;
                out_data  <= in_data;
                sel       <= pick_idx;
                out_valid <= 4'b0001 << pick_idx;
            end else if (xfer) begin
                state     <= ST_IDLE;
                out_valid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Directed bench for demux_rr_dispatcher: inputs change and outputs are checked on the falling edge.
module tb_demux_rr_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  en_mask;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [3:0]  out_valid;
    logic [7:0]  out_data;
    logic [3:0]  out_ready;
    logic [1:0]  sel;
    logic [15:0] xfer_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    demux_rr_dispatcher #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_mask   (en_mask),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .xfer_cnt  (xfer_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        en_mask   = 4'b1111;
        in_valid  = 1'b1;
        in_data   = 8'h00;
        out_ready = 4'b1111;

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 4'b0000);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_sel", sel, 2'd0);
        chk("rst_xfer_cnt", xfer_cnt, 16'd0);
        chk("rst_in_ready", in_ready, 1'b0);

        // four items 1,0,1,1 to a,b,c,d back-to-back
        rst_n   = 1'b1;
        in_data = 8'h01;
        #1 chk("b2b_in_ready_idle", in_ready, 1'b1);
        @(negedge clk);
        chk("b2b_v0", out_valid, 4'b0001);
        chk("b2b_d0", out_data, 8'h01);
        in_data = 8'h00;
        @(negedge clk);
        chk("b2b_v1", out_valid, 4'b0010);
        chk("b2b_d1", out_data, 8'h00);
        in_data = 8'h01;
        @(negedge clk);
        chk("b2b_v2", out_valid, 4'b0100);
        chk("b2b_d2", out_data, 8'h01);
        in_data = 8'h01;
        @(negedge clk);
        chk("b2b_v3", out_valid, 4'b1000);
        chk("b2b_d3", out_data, 8'h01);
        chk("b2b_sel3", sel, 2'd3);
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_idle_valid", out_valid, 4'b0000);
        chk("b2b_cnt", xfer_cnt, 16'd4);

        // mask 0101: six items alternate a,c
        en_mask  = 4'b0101;
        in_valid = 1'b1;
        in_data  = 8'h10;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("ac_valid", out_valid, (i % 2 == 1) ? 4'b0100 : 4'b0001);
            chk("ac_data", out_data, 8'h10 + i);
            if (i < 5) in_data = 8'h11 + 8'(i);
            else in_valid = 1'b0;
        end
        @(negedge clk);
        chk("ac_idle_valid", out_valid, 4'b0000);
        chk("ac_cnt", xfer_cnt, 16'd10);

        // channel b stalled for five cycles
        en_mask   = 4'b0010;
        out_ready = 4'b1101;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        @(negedge clk);
        in_data = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", out_valid, 4'b0010);
            chk("stall_data", out_data, 8'h5A);
            chk("stall_sel", sel, 2'd1);
            chk("stall_in_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        out_ready = 4'b1111;
        in_valid  = 1'b0;
        #1 chk("stall_release_in_ready", in_ready, 1'b1);
        @(negedge clk);
        chk("stall_done_valid", out_valid, 4'b0000);
        chk("stall_done_cnt", xfer_cnt, 16'd11);

        // held item to c survives en_mask cleared to zero
        en_mask   = 4'b0100;
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_data   = 8'h33;
        @(negedge clk);
        chk("mask0_hold_valid", out_valid, 4'b0100);
        en_mask = 4'b0000;
        in_data = 8'h44;
        #1 chk("mask0_in_ready", in_ready, 1'b0);
        @(negedge clk);
        chk("mask0_still_held", out_valid, 4'b0100);
        chk("mask0_data", out_data, 8'h33);
        out_ready = 4'b1111;
        #1 chk("mask0_in_ready_rdy", in_ready, 1'b0);
        @(negedge clk);
        chk("mask0_delivered_valid", out_valid, 4'b0000);
        chk("mask0_delivered_cnt", xfer_cnt, 16'd12);
        chk("mask0_idle_in_ready", in_ready, 1'b0);
        @(negedge clk);
        chk("mask0_idle2_valid", out_valid, 4'b0000);
        chk("mask0_idle2_cnt", xfer_cnt, 16'd12);
        en_mask = 4'b1000;
        #1 chk("mask_restore_in_ready", in_ready, 1'b1);
        @(negedge clk);
        chk("mask_restore_valid", out_valid, 4'b1000);
        chk("mask_restore_data", out_data, 8'h44);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mask_restore_cnt", xfer_cnt, 16'd13);

        // reset asserted while holding an item for b
        en_mask   = 4'b0010;
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        @(negedge clk);
        chk("rsthold_valid", out_valid, 4'b0010);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 4'b1111;
        #1 chk("rsthold_in_ready", in_ready, 1'b0);
        @(negedge clk);
        chk("rsthold_out_valid", out_valid, 4'b0000);
        chk("rsthold_cnt", xfer_cnt, 16'd0);
        chk("rsthold_sel", sel, 2'd0);
        rst_n    = 1'b1;
        en_mask  = 4'b1111;
        in_valid = 1'b1;
        in_data  = 8'h99;
        @(negedge clk);
        chk("rsthold_next_valid", out_valid, 4'b0001);
        chk("rsthold_next_data", out_data, 8'h99);
        in_valid = 1'b0;
        @(negedge clk);
        chk("rsthold_next_cnt", xfer_cnt, 16'd1);

        // counter wrap: stream until 16'hFFFF, then one final transfer
        in_valid = 1'b1;
        n = 0;
        while (xfer_cnt !== 16'hFFFF && n < 70000) begin
            @(negedge clk);
            n++;
        end
        chk("wrap_reached_max", xfer_cnt, 16'hFFFF);
        chk("wrap_holding", out_valid != 4'b0000, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("wrap_cnt_zero", xfer_cnt, 16'd0);
        chk("wrap_idle_valid", out_valid, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_rr_dispatcher.md
DEMUX_RR_DISPATCHER -- requirements
Module: demux_rr_dispatcher

Interface
REQ-001 Parameter: WIDTH, default 1, data width of each item routed through the 1-to-4 demux path.
REQ-002 Ports, one per line, clock and reset first:
 clk  input  1  single clock; all state updates on rising edge.
 rst_n  input  1  reset, synchronous, active-low.
 en_mask  input  4  per-channel enable; bit i set = channel i eligible for new items.
 in_valid  input  1  upstream item available.
 in_data  input  WIDTH  upstream item.
 in_ready  output  1  dispatcher accepts item this cycle.
 out_valid  output  4  one-hot (or zero) valid to channels a..d (bit0=a ... bit3=d).
 out_data  output  WIDTH  held item, shared by all channels (demux data path).
 out_ready  input  4  per-channel ready.
 sel  output  2  index of channel currently targeted (drives demux select).
 xfer_cnt  output  16  count of completed output transfers, wraps at 65535->0.

Function
REQ-003 The block SHALL implement a two-state FSM: IDLE (holding register empty) and HOLD (holding register full, item presented to channel sel).
REQ-004 Output transfer SHALL occur when out_valid[sel] and out_ready[sel] are both 1 in the same cycle.
REQ-005 in_ready SHALL be combinational: 1 in IDLE when en_mask != 0; in HOLD equal to (out_ready[sel] and en_mask != 0); 0 otherwise.
REQ-006 Input acceptance SHALL occur when in_valid and in_ready are both 1; the item SHALL be captured into the holding register and the state SHALL become or remain HOLD.
REQ-007 Target selection SHALL be round-robin: the new sel is the first enabled channel strictly after last-granted pointer lp, searching lp+1, lp+2, lp+3, lp (mod 4).
REQ-008 lp SHALL update to sel on every output transfer; the next target SHALL be computed from the updated lp in the same cycle, giving one item per cycle back-to-back throughput.
REQ-009 out_valid, out_data and sel SHALL be registered; out_valid SHALL have at most one bit set, bit sel, and only in HOLD.
REQ-010 Latency: an item accepted in cycle N SHALL be presented on out_valid/out_data in cycle N+1.
REQ-011 HOLD with transfer and no new input SHALL return to IDLE with out_valid = 0.
REQ-012 HOLD without transfer SHALL keep out_data, sel and out_valid stable (no retarget, no drop).
REQ-013 en_mask changes SHALL affect only the selection of subsequent items; an item already in HOLD SHALL be delivered to its original sel even if that channel is disabled.
REQ-014 en_mask = 0 SHALL block new acceptance but SHALL NOT block delivery of a held item.
REQ-015 xfer_cnt SHALL increment by 1 on each output transfer, wrapping from 16'hFFFF to 0.
REQ-016 No item SHALL be duplicated or lost across any sequence of inputs.

Reset
REQ-017 While rst_n = 0 at a clock edge: state = IDLE, out_valid = 0, out_data = 0, sel = 0, lp = 3 (so the first item goes to channel 0 when enabled), xfer_cnt = 0.
REQ-018 Reset asserted mid-HOLD SHALL discard the held item without an output transfer.
REQ-019 in_ready SHALL be 0 while rst_n = 0.

Structure
REQ-020 A shared package SHALL hold the FSM state enumeration, constant NUM_CH = 4, and the counter width constant 16.
REQ-021 Round-robin search SHALL be a sub-module rr_pick (inputs: 4-bit mask, 2-bit pointer; outputs: 2-bit index, found flag), purely combinational.

Verification
REQ-022 Reset then en_mask=4'b1111, all out_ready=1, four items 1,0,1,1 back-to-back -> out_valid 0001,0010,0100,1000 on consecutive cycles, data 1,0,1,1, xfer_cnt=4.
REQ-023 en_mask=4'b0101, six items -> channels a,c,a,c,a,c; b and d never valid.
REQ-024 Item held to channel b with out_ready[1]=0 for 5 cycles -> out_valid=0010, out_data and sel stable, in_ready=0; on out_ready[1]=1, transfer in that cycle.
REQ-025 Item in HOLD to c, en_mask cleared to 0 -> item still delivered to c, then in_ready=0 and out_valid=0 until en_mask nonzero.
REQ-026 rst_n=0 asserted during HOLD -> next cycle out_valid=0, xfer_cnt=0, sel=0; next item goes to channel a.
REQ-027 Preload 65535 transfers (or force the counter), one more transfer -> xfer_cnt wraps to 0.
